isa_io_master: RTL and testbench

Converts single I/O commands from the HPS-facing command port into timed ISA I/O read/write cycles on the exported ISA conduit (16-bit address, 16-bit bidirectional data, I/O read and write strobes). It sits directly upstream of the ISA conduit pins that feed the CT2960 riser. It owns strobe timing, IOCHRDY wait-state extension and read-data capture. One transaction is in flight at a time, and every transaction returns one completion.

---
 rtl/isa_pkg.sv | 30 +++
 rtl/isa_sync2.sv | 26 ++
 rtl/isa_io_master.sv | 174 +++++++++++++++++
 tb/tb_isa_io_master.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - shared types and timing defaults for the ISA I/O master
package isa_pkg;

  localparam int ISA_ADDR_W = 16;
  localparam int ISA_DATA_W = 16;

  localparam int ISA_SETUP_DEF   = 2;
  localparam int ISA_STROBE_DEF  = 10;
  localparam int ISA_HOLD_DEF    = 2;
  localparam int ISA_TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_WAIT,
    ST_HOLD,
    ST_RESP
  } isa_state_e;

  function automatic int isa_max4(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/isa_sync2.sv
// rtl/isa_sync2.sv - two-flop synchronizer for the asynchronous IOCHRDY input
module isa_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/isa_io_master.sv
// rtl/isa_io_master.sv - turns single I/O commands into timed ISA IOR/IOW cycles
// Define ISA_IOCHRDY_EN to build IOCHRDY wait-state extension with timeout.
module isa_io_master
  import isa_pkg::*;
#(
  parameter int SETUP_CYCLES   = ISA_SETUP_DEF,
  parameter int STROBE_CYCLES  = ISA_STROBE_DEF,
  parameter int HOLD_CYCLES    = ISA_HOLD_DEF,
  parameter int TIMEOUT_CYCLES = ISA_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic                  cmd_byte,
  input  logic [ISA_ADDR_W-1:0] cmd_addr,
  input  logic [ISA_DATA_W-1:0] cmd_wdata,
  output logic                  rsp_valid,
  output logic [ISA_DATA_W-1:0] rsp_rdata,
  output logic                  rsp_timeout,
  output logic [ISA_ADDR_W-1:0] isa_addr,
  output logic [ISA_DATA_W-1:0] isa_data_o,
  output logic                  isa_data_oe,
  input  logic [ISA_DATA_W-1:0] isa_data_i,
  output logic                  isa_ior_n,
  output logic                  isa_iow_n,
  input  logic                  isa_iochrdy
);

  localparam int CNT_W = $clog2(isa_max4(SETUP_CYCLES, STROBE_CYCLES,
                                         HOLD_CYCLES, TIMEOUT_CYCLES) + 1);
  typedef logic [CNT_W-1:0] cnt_t;

  isa_state_e            state_q, state_d;
  cnt_t                  cnt_q, cnt_d;
  logic [ISA_ADDR_W-1:0] addr_q, addr_d;
  logic [ISA_DATA_W-1:0] wdata_q, wdata_d;
  logic [ISA_DATA_W-1:0] rdata_q, rdata_d;
  logic                  write_q, write_d;
  logic                  byte_q, byte_d;
  logic                  timeout_q, timeout_d;
  logic                  rdy_sync;
  logic                  capture;
  logic                  strobe_low;

`ifdef ISA_IOCHRDY_EN
  isa_sync2 #(.RESET_VAL(1'b1)) u_sync (
    .clk_i   (clk),
    .reset_i (reset),
    .d_i     (isa_iochrdy),
    .q_o     (rdy_sync)
  );
`else
  logic unused_inputs;
  assign unused_inputs = isa_iochrdy ^ timeout_q;
  assign rdy_sync      = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      write_q   <= 1'b0;
      byte_q    <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      write_q   <= write_d;
      byte_q    <= byte_d;
      timeout_q <= timeout_d;
    end
  end

  // Each timed state reloads the shared down-counter on entry and exits at zero.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    write_d   = write_q;
    byte_d    = byte_q;
    timeout_d = timeout_q;
    capture   = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          state_d   = ST_SETUP;
          cnt_d     = cnt_t'(SETUP_CYCLES - 1);
          addr_d    = cmd_addr;
          wdata_d   = cmd_byte ? {cmd_wdata[7:0], cmd_wdata[7:0]} : cmd_wdata;
          rdata_d   = '0;
          write_d   = cmd_write;
          byte_d    = cmd_byte;
          timeout_d = 1'b0;
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          state_d = ST_STROBE;
          cnt_d   = cnt_t'(STROBE_CYCLES - 1);
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          if (rdy_sync) begin
            state_d = ST_HOLD;
            cnt_d   = cnt_t'(HOLD_CYCLES - 1);
            capture = 1'b1;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = cnt_t'(TIMEOUT_CYCLES - 1);
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_WAIT: begin
        if (rdy_sync || cnt_q == '0) begin
          state_d   = ST_HOLD;
          cnt_d     = cnt_t'(HOLD_CYCLES - 1);
          capture   = 1'b1;
          timeout_d = !rdy_sync;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    if (capture && !write_q) begin
      rdata_d = byte_q ? {{(ISA_DATA_W-8){1'b0}}, isa_data_i[7:0]} : isa_data_i;
    end
  end

  always_comb begin
    strobe_low  = (state_q == ST_STROBE) || (state_q == ST_WAIT);
    cmd_ready   = (state_q == ST_IDLE) && !reset;
    rsp_valid   = (state_q == ST_RESP);
    rsp_rdata   = (state_q == ST_RESP) ? rdata_q : '0;
`ifdef ISA_IOCHRDY_EN
    rsp_timeout = (state_q == ST_RESP) && timeout_q;
`else
    rsp_timeout = 1'b0;
`endif
    isa_addr    = addr_q;
    isa_data_o  = wdata_q;
    isa_data_oe = write_q && (state_q == ST_SETUP || strobe_low || state_q == ST_HOLD);
    isa_ior_n   = !(strobe_low && !write_q);
    isa_iow_n   = !(strobe_low && write_q);
  end

endmodule

// File: tb/tb_isa_io_master.sv
// tb/tb_isa_io_master.sv - directed bench with a timeline model of ISA I/O cycles
module tb_isa_io_master;

  localparam int S = 2;
  localparam int P = 10;
  localparam int H = 2;
  localparam int T = 1024;

`ifdef ISA_IOCHRDY_EN
  localparam int WAIT20_LOW = 21;
  localparam int WAIT20_RSP = 26;
  localparam int STUCK_LOW  = 1034;
  localparam int STUCK_RSP  = 1039;
  localparam int STUCK_TO   = 1;
`else
  localparam int WAIT20_LOW = 10;
  localparam int WAIT20_RSP = 15;
  localparam int STUCK_LOW  = 10;
  localparam int STUCK_RSP  = 15;
  localparam int STUCK_TO   = 0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid, cmd_ready, cmd_write, cmd_byte;
  logic [15:0] cmd_addr, cmd_wdata;
  logic        rsp_valid, rsp_timeout;
  logic [15:0] rsp_rdata;
  logic [15:0] isa_addr, isa_data_o, isa_data_i;
  logic        isa_data_oe, isa_ior_n, isa_iow_n, isa_iochrdy;

  always #5 clk = ~clk;

  isa_io_master #(
    .SETUP_CYCLES(S), .STROBE_CYCLES(P), .HOLD_CYCLES(H), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_byte(cmd_byte), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
    .isa_addr(isa_addr), .isa_data_o(isa_data_o), .isa_data_oe(isa_data_oe),
    .isa_data_i(isa_data_i), .isa_ior_n(isa_ior_n), .isa_iow_n(isa_iow_n),
    .isa_iochrdy(isa_iochrdy)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;
  int lo_start = 0;
  int lo_end   = 0;

  bit          have_txn = 1'b0;
  bit          m_clean  = 1'b1;
  bit          m_write, m_byte, m_to;
  int          m_a, m_w;
  logic [15:0] m_addr, m_wd, m_rd;

  int          iow_cnt = 0, ior_cnt = 0, rsp_seen = 0, rsp_cyc = 0;
  logic [15:0] st_addr, st_data, last_rdata;
  logic        last_to;
  int          dut_acc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d actual=%h required=%h", name, cyc, act, exp);
    end
  endtask

  function automatic bit rdy_at(input int c);
    return !(c >= lo_start && c < lo_end);
  endfunction

  function automatic bit m_busy(input int c);
    return have_txn && c >= m_a + 1 && c <= m_a + S + P + m_w + H + 1;
  endfunction

  // Acceptance fixes the whole timeline: wait length follows from the IOCHRDY
  // schedule seen two cycles late through the synchronizer.
  always @(posedge clk) begin : model
    int w, f;
    bit to;
    if (reset) begin
      have_txn <= 1'b0;
      m_clean  <= 1'b1;
    end else if (cmd_valid && !m_busy(cyc)) begin
      f  = cyc + S + P;
      w  = 0;
      to = 1'b0;
`ifdef ISA_IOCHRDY_EN
      if (!rdy_at(f - 2)) begin
        w  = T;
        to = 1'b1;
        for (int k = 1; k <= T; k++) begin
          if (to && rdy_at(f + k - 2)) begin
            w  = k;
            to = 1'b0;
          end
        end
      end
`endif
      have_txn <= 1'b1;
      m_clean  <= 1'b0;
      m_a      <= cyc;
      m_w      <= w;
      m_to     <= to;
      m_write  <= cmd_write;
      m_byte   <= cmd_byte;
      m_addr   <= cmd_addr;
      m_wd     <= cmd_byte ? {cmd_wdata[7:0], cmd_wdata[7:0]} : cmd_wdata;
      m_rd     <= cmd_write ? 16'h0000 : (cmd_byte ? {8'h00, isa_data_i[7:0]} : isa_data_i);
    end
    cyc <= cyc + 1;
  end

  always @(negedge clk) begin : cmp
    bit busy, stb, oe, rv;
    if (chk_en) begin
      busy = m_busy(cyc);
      stb  = have_txn && cyc >= m_a + S + 1 && cyc <= m_a + S + P + m_w;
      oe   = have_txn && m_write && cyc >= m_a + 1 && cyc <= m_a + S + P + m_w + H;
      rv   = have_txn && cyc == m_a + S + P + m_w + H + 1;
      check("cmd_ready", cmd_ready, !reset && !busy);
      check("isa_ior_n", isa_ior_n, !(stb && !m_write));
      check("isa_iow_n", isa_iow_n, !(stb && m_write));
      check("no_overlap", isa_ior_n | isa_iow_n, 1);
      check("isa_data_oe", isa_data_oe, oe);
      check("rsp_valid", rsp_valid, rv);
      if (rv) begin
        check("rsp_rdata", rsp_rdata, m_rd);
        check("rsp_timeout", rsp_timeout, m_to);
      end
      if (busy && !rv) begin
        check("isa_addr", isa_addr, m_addr);
        if (m_write) check("isa_data_o", isa_data_o, m_wd);
      end
      if (m_clean && !have_txn) begin
        check("idle_addr", isa_addr, 0);
        check("idle_data_o", isa_data_o, 0);
        check("idle_rdata", rsp_rdata, 0);
        check("idle_timeout", rsp_timeout, 0);
      end
      if (!isa_iow_n) iow_cnt++;
      if (!isa_ior_n) ior_cnt++;
      if (!isa_iow_n || !isa_ior_n) begin
        st_addr = isa_addr;
        st_data = isa_data_o;
      end
      if (rsp_valid) begin
        rsp_seen++;
        rsp_cyc    = cyc;
        last_rdata = rsp_rdata;
        last_to    = rsp_timeout;
      end
      if (cmd_valid && cmd_ready) dut_acc.push_back(cyc);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    isa_iochrdy = rdy_at(cyc);
  endtask

  task automatic issue(input logic w, input logic b, input logic [15:0] ad,
                       input logic [15:0] wd, input logic [15:0] di, output int acc);
    cmd_write  = w;
    cmd_byte   = b;
    cmd_addr   = ad;
    cmd_wdata  = wd;
    isa_data_i = di;
    cmd_valid  = 1'b1;
    iow_cnt    = 0;
    ior_cnt    = 0;
    acc        = -1;
    for (int n = 0; n < 200 && acc < 0; n++) begin
      tick();
      if (have_txn && m_a == cyc - 1) acc = cyc - 1;
    end
    cmd_valid = 1'b0;
    check("accepted", acc >= 0, 1);
  endtask

  task automatic wait_rsp(input int start, input int budget);
    int n;
    n = 0;
    while (rsp_seen == start && n < budget) begin
      tick();
      n++;
    end
    check("rsp_arrived", rsp_seen != start, 1);
  endtask

  initial begin
    int acc, acc2, rs;
    reset       = 1'b1;
    cmd_valid   = 1'b0;
    cmd_write   = 1'b0;
    cmd_byte    = 1'b0;
    cmd_addr    = '0;
    cmd_wdata   = '0;
    isa_data_i  = '0;
    isa_iochrdy = 1'b1;

    tick();
    chk_en = 1'b1;
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_iow_n", isa_iow_n, 1);
    check("rst_ior_n", isa_ior_n, 1);
    check("rst_oe", isa_data_oe, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_addr", isa_addr, 16'h0000);
    tick();
    reset = 1'b0;
    #1;
    check("ready_after_reset", cmd_ready, 1);
    tick();

    // byte write 0x00AB to 0x0220
    rs = rsp_seen;
    issue(1'b1, 1'b1, 16'h0220, 16'h00AB, 16'h0000, acc);
    wait_rsp(rs, 100);
    check("wr_iow_len", iow_cnt, 10);
    check("wr_ior_len", ior_cnt, 0);
    check("wr_addr", st_addr, 16'h0220);
    check("wr_data", st_data, 16'hABAB);
    check("wr_rsp_lat", rsp_cyc - acc, 15);
    check("wr_rdata", last_rdata, 16'h0000);

    // 16-bit read then byte read of 0x022A
    rs = rsp_seen;
    issue(1'b0, 1'b0, 16'h022A, 16'h0000, 16'h1234, acc);
    wait_rsp(rs, 100);
    check("rd16_ior_len", ior_cnt, 10);
    check("rd16_rdata", last_rdata, 16'h1234);
    check("rd16_addr", st_addr, 16'h022A);
    rs = rsp_seen;
    issue(1'b0, 1'b1, 16'h022A, 16'h0000, 16'h1234, acc);
    wait_rsp(rs, 100);
    check("rd8_rdata", last_rdata, 16'h0034);

    // IOCHRDY low for 20 cycles
    lo_start = cyc + 1;
    lo_end   = cyc + 21;
    rs = rsp_seen;
    issue(1'b0, 1'b0, 16'h0300, 16'h0000, 16'hBEEF, acc);
    wait_rsp(rs, 200);
    check("wait20_ior_len", ior_cnt, WAIT20_LOW);
    check("wait20_rsp_lat", rsp_cyc - acc, WAIT20_RSP);
    check("wait20_timeout", last_to, 0);
    check("wait20_rdata", last_rdata, 16'hBEEF);
    tick();

    // IOCHRDY stuck low
    lo_start = cyc + 1;
    lo_end   = cyc + 5000;
    rs = rsp_seen;
    issue(1'b1, 1'b0, 16'h0310, 16'h55AA, 16'h0000, acc);
    wait_rsp(rs, 2000);
    check("stuck_iow_len", iow_cnt, STUCK_LOW);
    check("stuck_rsp_lat", rsp_cyc - acc, STUCK_RSP);
    check("stuck_timeout", last_to, STUCK_TO);
    lo_start = 0;
    lo_end   = 0;
    tick();
    tick();
    tick();

    // reset during STROBE
    rs = rsp_seen;
    issue(1'b1, 1'b0, 16'h0320, 16'h1111, 16'h0000, acc);
    while (cyc < acc + 5) tick();
    check("pre_reset_iow", isa_iow_n, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check("abort_iow_n", isa_iow_n, 1);
    check("abort_ior_n", isa_ior_n, 1);
    check("abort_oe", isa_data_oe, 0);
    check("abort_ready", cmd_ready, 1);
    for (int i = 0; i < 20; i++) tick();
    check("abort_no_rsp", rsp_seen - rs, 0);

    // back-to-back commands
    rs = rsp_seen;
    issue(1'b1, 1'b0, 16'h0300, 16'h5A5A, 16'h0000, acc);
    issue(1'b1, 1'b1, 16'h0301, 16'h00C3, 16'h0000, acc2);
    check("b2b_model_gap", acc2 - acc, 16);
    check("b2b_dut_gap", dut_acc[dut_acc.size()-1] - dut_acc[dut_acc.size()-2], 16);
    wait_rsp(rs + 1, 100);
    check("b2b_rsp_lat", rsp_cyc - acc2, 15);
    check("b2b_data", st_data, 16'hC3C3);
    tick();
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
